// File: rtl/parking_pkg.sv
// Shared constants, FSM encoding and timestamp helper for the parking fee calculator.
package parking_pkg;

  localparam int MIN_PER_HOUR = 60;
  localparam int MIN_PER_DAY  = 1440;
  localparam int TS_W         = 18;
  localparam int ELAPSED_W    = 19;

  typedef enum logic [2:0] {
    IDLE,
    DIFF,
    DIV,
    SCALE,
    DONE
  } state_t;

  function automatic logic [TS_W-1:0] to_minutes(input logic [6:0] d,
                                                  input logic [4:0] h,
                                                  input logic [6:0] m);
    return TS_W'(d) * TS_W'(MIN_PER_DAY) + TS_W'(h) * TS_W'(MIN_PER_HOUR) + TS_W'(m);
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring divider: one quotient bit per cycle, WIDTH cycles after i_start.
// o_done is high during the final iteration; o_quot is complete from the next cycle.
module seq_divider #(
  parameter int WIDTH = 19
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_done,
  output logic [WIDTH-1:0] o_quot
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quot;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_sub;

  always_comb begin
    w_shift = {r_rem, r_quot[WIDTH-1]};
    w_sub   = w_shift - {1'b0, i_divisor};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem  <= '0;
      r_quot <= '0;
      r_cnt  <= '0;
    end else if (i_start) begin
      r_rem  <= '0;
      r_quot <= i_dividend;
      r_cnt  <= CW'(WIDTH);
    end else if (r_cnt != '0) begin
      if (w_shift >= {1'b0, i_divisor}) begin
        r_rem  <= w_sub[WIDTH-1:0];
        r_quot <= {r_quot[WIDTH-2:0], 1'b1};
      end else begin
        r_rem  <= w_shift[WIDTH-1:0];
        r_quot <= {r_quot[WIDTH-2:0], 1'b0};
      end
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign o_done = (r_cnt == CW'(1));
  assign o_quot = r_quot;

endmodule

// File: rtl/parking_fee_calc.sv
// Per-slot entry timestamp store and fixed-latency fee computation on exit
// (DIFF -> 19-cycle DIV -> SCALE -> DONE).
module parking_fee_calc
  import parking_pkg::*;
#(
  parameter int SLOTS    = 4,
  parameter int UNIT_MIN = 60,
  parameter int RATE     = 5,
  parameter int MAX_FEE  = 200,
  parameter int FEE_W    = 16,
  parameter int DAY_WRAP = 128
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [6:0]               day,
  input  logic [4:0]               hour,
  input  logic [6:0]               minute,
  input  logic                     entry_valid,
  input  logic [$clog2(SLOTS)-1:0] entry_slot,
  input  logic                     exit_valid,
  input  logic [$clog2(SLOTS)-1:0] exit_slot,
  output logic                     exit_ready,
  output logic                     busy,
  output logic [SLOTS-1:0]         occupied,
  output logic                     entry_err,
  output logic                     exit_err,
  output logic                     fee_valid,
  output logic [$clog2(SLOTS)-1:0] fee_slot,
  output logic [ELAPSED_W-1:0]     elapsed_min,
  output logic [FEE_W-1:0]         fee
);

  localparam int SW = $clog2(SLOTS);

  state_t                r_state;
  logic [TS_W-1:0]       r_ts [SLOTS];
  logic [TS_W-1:0]       r_t_in;
  logic [TS_W-1:0]       r_t_out;
  logic [SW-1:0]         r_slot;
  logic [ELAPSED_W-1:0]  r_elapsed;

  logic [TS_W-1:0]       w_now;
  logic                  w_exit_acc;
  logic                  w_exit_hit;
  logic                  w_entry_ok;
  logic [SLOTS-1:0]      w_set;
  logic [SLOTS-1:0]      w_clr;
  logic [ELAPSED_W-1:0]  w_diff;
  logic [ELAPSED_W-1:0]  w_dividend;
  logic                  w_div_done;
  logic [ELAPSED_W-1:0]  w_quot;
  logic [31:0]           w_prod;
  logic [FEE_W-1:0]      w_fee;

  assign w_now      = to_minutes(day, hour, minute);
  // Entry and exit are both judged against the pre-edge occupancy.
  assign w_exit_acc = exit_valid & ~busy;
  assign w_exit_hit = w_exit_acc & occupied[exit_slot];
  assign w_entry_ok = entry_valid & ~occupied[entry_slot];
  assign w_set      = w_entry_ok ? (SLOTS'(1) << entry_slot) : '0;
  assign w_clr      = w_exit_hit ? (SLOTS'(1) << exit_slot) : '0;
  assign exit_ready = ~busy;

  always_comb begin
    w_diff = ELAPSED_W'(r_t_out) - ELAPSED_W'(r_t_in);
    if (r_t_out < r_t_in) w_diff = w_diff + ELAPSED_W'(DAY_WRAP * MIN_PER_DAY);
    w_dividend = w_diff + ELAPSED_W'(UNIT_MIN - 1);
    w_prod     = 32'(w_quot) * 32'(RATE);
    w_fee      = (w_prod > 32'(MAX_FEE)) ? FEE_W'(MAX_FEE) : FEE_W'(w_prod);
  end

  seq_divider #(.WIDTH(ELAPSED_W)) u_div (
    .clk        (clk),
    .rst_n      (reset),
    .i_start    (r_state == DIFF),
    .i_dividend (w_dividend),
    .i_divisor  (ELAPSED_W'(UNIT_MIN)),
    .o_done     (w_div_done),
    .o_quot     (w_quot)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      for (int unsigned i = 0; i < SLOTS; i++) r_ts[i] <= '0;
      r_t_in      <= '0;
      r_t_out     <= '0;
      r_slot      <= '0;
      r_elapsed   <= '0;
      busy        <= 1'b0;
      occupied    <= '0;
      entry_err   <= 1'b0;
      exit_err    <= 1'b0;
      fee_valid   <= 1'b0;
      fee_slot    <= '0;
      elapsed_min <= '0;
      fee         <= '0;
    end else begin
      entry_err <= entry_valid & occupied[entry_slot];
      exit_err  <= w_exit_acc & ~occupied[exit_slot];
      fee_valid <= 1'b0;
      occupied  <= (occupied & ~w_clr) | w_set;
      if (w_entry_ok) r_ts[entry_slot] <= w_now;
      case (r_state)
        IDLE: if (w_exit_hit) begin
          r_t_in  <= r_ts[exit_slot];
          r_t_out <= w_now;
          r_slot  <= exit_slot;
          busy    <= 1'b1;
          r_state <= DIFF;
        end
        DIFF: begin
          r_elapsed <= w_diff;
          r_state   <= DIV;
        end
        DIV: if (w_div_done) r_state <= SCALE;
        SCALE: begin
          fee         <= w_fee;
          elapsed_min <= r_elapsed;
          fee_slot    <= r_slot;
          fee_valid   <= 1'b1;
          r_state     <= DONE;
        end
        DONE: begin
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_parking_fee_calc.sv
// Directed bench for parking_fee_calc with hand-computed fees (RATE=5, UNIT_MIN=60, MAX_FEE=200).
module tb_parking_fee_calc;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  day;
  logic [4:0]  hour;
  logic [6:0]  minute;
  logic        entry_valid;
  logic [1:0]  entry_slot;
  logic        exit_valid;
  logic [1:0]  exit_slot;
  logic        exit_ready;
  logic        busy;
  logic [3:0]  occupied;
  logic        entry_err;
  logic        exit_err;
  logic        fee_valid;
  logic [1:0]  fee_slot;
  logic [18:0] elapsed_min;
  logic [15:0] fee;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  parking_fee_calc #(
    .SLOTS(4), .UNIT_MIN(60), .RATE(5), .MAX_FEE(200), .FEE_W(16), .DAY_WRAP(128)
  ) dut (
    .clk(clk), .reset(reset), .day(day), .hour(hour), .minute(minute),
    .entry_valid(entry_valid), .entry_slot(entry_slot),
    .exit_valid(exit_valid), .exit_slot(exit_slot),
    .exit_ready(exit_ready), .busy(busy), .occupied(occupied),
    .entry_err(entry_err), .exit_err(exit_err),
    .fee_valid(fee_valid), .fee_slot(fee_slot),
    .elapsed_min(elapsed_min), .fee(fee)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_t(input int d, input int h, input int m);
    day = 7'(d); hour = 5'(h); minute = 7'(m);
  endtask

  task automatic do_entry(input int s);
    @(negedge clk);
    entry_valid = 1'b1; entry_slot = 2'(s);
    @(posedge clk); #1;
    entry_valid = 1'b0;
  endtask

  task automatic do_exit(input int s);
    @(negedge clk);
    exit_valid = 1'b1; exit_slot = 2'(s);
    @(posedge clk); #1;
    exit_valid = 1'b0;
  endtask

  task automatic do_both(input int s);
    @(negedge clk);
    entry_valid = 1'b1; entry_slot = 2'(s);
    exit_valid  = 1'b1; exit_slot  = 2'(s);
    @(posedge clk); #1;
    entry_valid = 1'b0; exit_valid = 1'b0;
  endtask

  task automatic wait_fee(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!fee_valid && n < 40);
  endtask

  task automatic count_fee(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (fee_valid) cnt++;
    end
  endtask

  // Called at #1 after the accept edge: result must appear 21 edges later.
  task automatic result(input string tag, input int s, input int el, input int f);
    int n;
    wait_fee(n);
    chk({tag, ".latency"}, n, 21);
    chk({tag, ".slot"}, 32'(fee_slot), s);
    chk({tag, ".elapsed"}, 32'(elapsed_min), el);
    chk({tag, ".fee"}, 32'(fee), f);
    chk({tag, ".busy_done"}, 32'(busy), 1);
    @(posedge clk); #1;
    chk({tag, ".valid_pulse"}, 32'(fee_valid), 0);
    chk({tag, ".ready_after"}, 32'(exit_ready), 1);
  endtask

  initial begin
    int n;
    int cnt;
    reset = 1'b0;
    entry_valid = 1'b0; entry_slot = '0;
    exit_valid  = 1'b0; exit_slot  = '0;
    set_t(0, 0, 0);
    #2;
    chk("rst.exit_ready", 32'(exit_ready), 1);
    chk("rst.busy", 32'(busy), 0);
    chk("rst.occupied", 32'(occupied), 0);
    chk("rst.fee_valid", 32'(fee_valid), 0);
    chk("rst.fee", 32'(fee), 0);
    @(negedge clk); @(negedge clk);
    reset = 1'b1;

    // Basic: d0 01:00 -> d0 03:30, 150 min, 3 units
    set_t(0, 1, 0);  do_entry(0);
    chk("basic.occ_in", 32'(occupied), 4'b0001);
    set_t(0, 3, 30); do_exit(0);
    chk("basic.busy", 32'(busy), 1);
    chk("basic.ready", 32'(exit_ready), 0);
    chk("basic.occ_out", 32'(occupied), 0);
    result("basic", 0, 150, 15);
    chk("basic.fee_hold", 32'(fee), 15);

    // Day wrap: d127 23:50 -> d0 00:20
    set_t(127, 23, 50); do_entry(1);
    set_t(0, 0, 20);    do_exit(1);
    result("wrap", 1, 30, 5);

    // Cap: 2880 min, 48 units -> 240 capped to 200
    set_t(1, 0, 0); do_entry(2);
    set_t(3, 0, 0); do_exit(2);
    result("cap", 2, 2880, 200);

    // Duplicate entry keeps first timestamp; exactly one unit
    set_t(0, 0, 10); do_entry(3);
    chk("dup.first_err", 32'(entry_err), 0);
    set_t(0, 5, 0);  do_entry(3);
    chk("dup.entry_err", 32'(entry_err), 1);
    @(posedge clk); #1;
    chk("dup.err_pulse", 32'(entry_err), 0);
    set_t(0, 1, 10); do_exit(3);
    result("dup", 3, 60, 5);

    // Exit from empty slot
    set_t(0, 2, 0); do_exit(2);
    chk("empty.exit_err", 32'(exit_err), 1);
    chk("empty.busy", 32'(busy), 0);
    chk("empty.ready", 32'(exit_ready), 1);
    @(posedge clk); #1;
    chk("empty.err_pulse", 32'(exit_err), 0);
    count_fee(25, cnt);
    chk("empty.no_fee", cnt, 0);

    // Zero duration
    set_t(5, 10, 0); do_entry(0);
    do_exit(0);
    result("zero", 0, 0, 0);

    // Simultaneous entry+exit, slot occupied: exit wins, entry flagged
    set_t(0, 0, 0);  do_entry(2);
    set_t(0, 0, 30); do_both(2);
    chk("sim_occ.entry_err", 32'(entry_err), 1);
    chk("sim_occ.exit_err", 32'(exit_err), 0);
    chk("sim_occ.busy", 32'(busy), 1);
    chk("sim_occ.occ", 32'(occupied), 0);
    result("sim_occ", 2, 30, 5);

    // Simultaneous entry+exit, slot empty: entry stored, exit flagged
    do_both(2);
    chk("sim_emp.exit_err", 32'(exit_err), 1);
    chk("sim_emp.entry_err", 32'(entry_err), 0);
    chk("sim_emp.busy", 32'(busy), 0);
    chk("sim_emp.occ", 32'(occupied), 4'b0100);
    set_t(0, 1, 30); do_exit(2);
    result("sim_emp", 2, 60, 5);

    // exit_valid held while busy: accepted once, after exit_ready returns
    set_t(0, 0, 0); do_entry(0); do_entry(1);
    set_t(0, 1, 1); do_exit(0);
    @(negedge clk);
    exit_valid = 1'b1; exit_slot = 2'd1;
    set_t(0, 2, 0);
    wait_fee(n);
    chk("hold.latency", n, 21);
    chk("hold.slot0", 32'(fee_slot), 0);
    chk("hold.elapsed0", 32'(elapsed_min), 61);
    chk("hold.fee0", 32'(fee), 10);
    chk("hold.occ_busy", 32'(occupied), 4'b0010);
    @(posedge clk); #1;
    chk("hold.ready", 32'(exit_ready), 1);
    chk("hold.occ_ready", 32'(occupied), 4'b0010);
    @(posedge clk); #1;
    exit_valid = 1'b0;
    chk("hold.accept", 32'(busy), 1);
    chk("hold.occ_acc", 32'(occupied), 0);
    result("hold", 1, 120, 10);
    count_fee(30, cnt);
    chk("hold.once", cnt, 0);

    // Reset in the middle of DIV
    set_t(0, 0, 0); do_entry(0); do_entry(3);
    set_t(0, 4, 0); do_exit(0);
    repeat (8) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("mid.busy", 32'(busy), 0);
    chk("mid.ready", 32'(exit_ready), 1);
    chk("mid.occ", 32'(occupied), 0);
    chk("mid.fee", 32'(fee), 0);
    chk("mid.elapsed", 32'(elapsed_min), 0);
    chk("mid.slot", 32'(fee_slot), 0);
    chk("mid.valid", 32'(fee_valid), 0);
    @(negedge clk);
    reset = 1'b1;
    count_fee(30, cnt);
    chk("mid.no_fee", cnt, 0);
    chk("mid.occ_after", 32'(occupied), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
